// File: rtl/fifo_arb_pkg.sv
// Shared defaults and helpers for the round-robin FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int DEF_N         = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_IW        = $clog2(DEF_N);

  // Ceiling log2, clamped to 1 so an index field never collapses to zero bits.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-write bundle of the arbiter; master = arbiter side, slave = requesters + FIFO side.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW
);
  localparam int IW = clog2(N);

  logic [N-1:0]    req;
  logic [N*DW-1:0] din_in;
  logic            full;
  logic [N-1:0]    gnt;
  logic            wen;
  logic [DW-1:0]   din;
  logic [IW-1:0]   owner;

  modport master (input req, din_in, full, output gnt, wen, din, owner);
  modport slave  (output req, din_in, full, input gnt, wen, din, owner);

endinterface

// File: rtl/rr_prio_pick.sv
// Round-robin pick: first set req bit at or after ptr (with wrap), via double-width rotate + priority encode.
module rr_prio_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  localparam logic [IW:0] NW = (IW+1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;

  always_comb begin
    w_dbl = {req, req};
    w_rot = w_dbl[ptr +: N];
    found = |w_rot;
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
    w_sum = {1'b0, ptr} + {1'b0, w_off};
    idx   = (w_sum >= NW) ? IW'(w_sum - NW) : IW'(w_sum);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters.
// Optional burst locking is enabled by defining FIFO_ARB_BURST_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.master  bus
);

  localparam int            IW   = clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == LAST) ? '0 : i + IW'(1);
  endfunction

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_owner;
  logic          w_found;
  logic [IW-1:0] w_idx;
  logic          w_vld;
  logic [IW-1:0] w_win;

  rr_prio_pick #(.N(N), .IW(IW)) u_pick (
    .req   (bus.req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

`ifdef FIFO_ARB_BURST_EN
  localparam int CW = clog2(MAX_BURST + 1);

  logic          r_lock;
  logic [CW-1:0] r_beat_cnt;
  logic          w_cont;

  // A locked owner that still requests keeps the port; otherwise fall back to round-robin.
  assign w_cont = r_lock && bus.req[r_owner];

  always_comb begin
    w_vld = 1'b0;
    w_win = w_idx;
    if (!rst && !bus.full) begin
      if (w_cont) begin
        w_vld = 1'b1;
        w_win = r_owner;
      end else begin
        w_vld = w_found;
      end
    end
  end

  // r_ptr is set to owner+1 on the first beat, so a release leaves it already pointing past the owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_owner    <= '0;
      r_lock     <= 1'b0;
      r_beat_cnt <= '0;
    end else if (!bus.full) begin
      if (w_vld && w_cont) begin
        if (r_beat_cnt == CW'(MAX_BURST - 1)) begin
          r_lock     <= 1'b0;
          r_beat_cnt <= '0;
        end else begin
          r_beat_cnt <= r_beat_cnt + CW'(1);
        end
      end else if (w_vld) begin
        r_owner <= w_win;
        r_ptr   <= next_idx(w_win);
        if (MAX_BURST > 1) begin
          r_lock     <= 1'b1;
          r_beat_cnt <= CW'(1);
        end else begin
          r_lock     <= 1'b0;
          r_beat_cnt <= '0;
        end
      end else if (r_lock) begin
        r_lock     <= 1'b0;
        r_beat_cnt <= '0;
      end
    end
  end
`else
  always_comb begin
    w_vld = 1'b0;
    w_win = w_idx;
    if (!rst && !bus.full) w_vld = w_found;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_owner <= '0;
    end else if (w_vld) begin
      r_owner <= w_win;
      r_ptr   <= next_idx(w_win);
    end
  end
`endif

  always_comb begin
    bus.gnt = '0;
    bus.din = '0;
    if (w_vld) begin
      bus.gnt[w_win] = 1'b1;
      bus.din        = bus.din_in[w_win*DW +: DW];
    end
  end

  assign bus.wen   = |bus.gnt;
  assign bus.owner = r_owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter against a queue-free round-robin reference model.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 3;
  localparam int IW = clog2(N);
`ifdef FIFO_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  fifo_wr_arbiter_if #(.N(N), .DW(DW)) bus ();

  fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int            m_ptr   = 0;
  int            m_owner = 0;
  int            m_cnt   = 0;
  bit            m_lock  = 1'b0;
  logic [DW-1:0] m_din [N];

  // Inputs of the current cycle and the expected outputs derived from them
  logic [N-1:0]  s_req;
  logic          s_full;
  logic          s_rst;
  int            e_w;
  logic [N-1:0]  e_gnt;
  logic [DW-1:0] e_din;

  function automatic int search(input logic [N-1:0] rq, input int start);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (rq[i]) return i;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs, compute expectations, and move to the sample point.
  task automatic set_in(input logic [N-1:0] rq, input logic f, input logic r);
    s_req = rq; s_full = f; s_rst = r;
    bus.req  = rq;
    bus.full = f;
    rst      = r;
    for (int i = 0; i < N; i++) bus.din_in[i*DW +: DW] = m_din[i];
    e_w = -1;
    if (!r && !f) begin
      if (m_lock && rq[m_owner]) e_w = m_owner;
      else if (m_lock)           e_w = search(rq, (m_owner + 1) % N);
      else                       e_w = search(rq, m_ptr);
    end
    e_gnt = '0;
    e_din = '0;
    if (e_w >= 0) begin
      e_gnt[e_w] = 1'b1;
      e_din      = m_din[e_w];
    end
    #4;
  endtask

  // Clock edge: advance the reference model by the rules, then step off the edge.
  task automatic adv();
    @(posedge clk);
    if (s_rst) begin
      m_ptr = 0; m_owner = 0; m_lock = 1'b0; m_cnt = 0;
    end else if (!s_full) begin
      if (m_lock && !s_req[m_owner]) begin
        m_lock = 1'b0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
      end
      if (e_w >= 0) begin
        if (m_lock) m_cnt++;
        else begin
          m_owner = e_w;
          m_ptr   = (e_w + 1) % N;
          if (BURST) begin m_lock = 1'b1; m_cnt = 1; end
        end
        if (m_lock && m_cnt == MB) begin
          m_lock = 1'b0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    set_in('0, 1'b0, 1'b1);
    adv();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      set_in(4'b1111, 1'b0, 1'b1);
      checks++;
      if (bus.gnt !== 4'b0000) begin
        failures++; $display("FAIL reset_gnt cyc=%0d got=%b want=0000", c, bus.gnt);
      end
      checks++;
      if (bus.wen !== 1'b0) begin
        failures++; $display("FAIL reset_wen cyc=%0d got=%b want=0", c, bus.wen);
      end
      checks++;
      if (bus.din !== 8'h00) begin
        failures++; $display("FAIL reset_din cyc=%0d got=%h want=00", c, bus.din);
      end
      adv();
    end
    set_in(4'b1111, 1'b0, 1'b0);
    checks++;
    if (bus.owner !== 2'd0) begin
      failures++; $display("FAIL reset_owner got=%0d want=0", bus.owner);
    end
    checks++;
    if (bus.gnt !== 4'b0001) begin
      failures++; $display("FAIL reset_first_gnt got=%b want=0001", bus.gnt);
    end
    adv();
  endtask

  task automatic test_rr_sequence();
    for (int i = 0; i < N; i++) m_din[i] = 8'h10 + 8'(i);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_in(4'b1111, 1'b0, 1'b0);
      checks++;
      if (bus.gnt !== e_gnt) begin
        failures++; $display("FAIL rr_gnt cyc=%0d got=%b want=%b", c, bus.gnt, e_gnt);
      end
      checks++;
      if (bus.din !== e_din) begin
        failures++; $display("FAIL rr_din cyc=%0d got=%h want=%h", c, bus.din, e_din);
      end
      adv();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_in(4'b0101, 1'b1, 1'b0);
      checks++;
      if (bus.gnt !== 4'b0000 || bus.wen !== 1'b0) begin
        failures++; $display("FAIL full_hold cyc=%0d got gnt=%b wen=%b want gnt=0000 wen=0", c, bus.gnt, bus.wen);
      end
      adv();
    end
    for (int c = 0; c < 2; c++) begin
      set_in(4'b0101, 1'b0, 1'b0);
      checks++;
      if (bus.gnt !== e_gnt) begin
        failures++; $display("FAIL full_release_gnt cyc=%0d got=%b want=%b", c, bus.gnt, e_gnt);
      end
      adv();
    end
    set_in(4'b0000, 1'b0, 1'b0);
    checks++;
    if (bus.owner !== IW'(m_owner)) begin
      failures++; $display("FAIL full_owner got=%0d want=%0d", bus.owner, m_owner);
    end
    adv();
  endtask

  task automatic test_single_requester();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_in(4'b0010, 1'b0, 1'b0);
      checks++;
      if (bus.gnt !== 4'b0010 || bus.wen !== 1'b1) begin
        failures++; $display("FAIL single_gnt cyc=%0d got gnt=%b wen=%b want gnt=0010 wen=1", c, bus.gnt, bus.wen);
      end
      adv();
    end
    set_in(4'b0000, 1'b0, 1'b0);
    checks++;
    if (bus.owner !== 2'd1) begin
      failures++; $display("FAIL single_owner got=%0d want=1", bus.owner);
    end
    adv();
  endtask

  task automatic test_burst_pause();
    do_reset();
    for (int c = 0; c < 13; c++) begin
      set_in(4'b1111, (c == 7) ? 1'b1 : 1'b0, 1'b0);
      checks++;
      if (bus.gnt !== e_gnt) begin
        failures++; $display("FAIL burst_gnt cyc=%0d got=%b want=%b", c, bus.gnt, e_gnt);
      end
      adv();
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_in(4'b1111, 1'b0, (c == 4) ? 1'b1 : 1'b0);
      checks++;
      if (bus.gnt !== e_gnt) begin
        failures++; $display("FAIL midrst_gnt cyc=%0d got=%b want=%b", c, bus.gnt, e_gnt);
      end
      adv();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) m_din[i] = DW'($urandom);
      set_in(N'($urandom_range(0, 15)), ($urandom_range(0, 9) < 3), ($urandom_range(0, 59) == 0));
      checks++;
      if (bus.gnt !== e_gnt || bus.din !== e_din) begin
        failures++; $display("FAIL rand_out cyc=%0d got gnt=%b din=%h want gnt=%b din=%h", c, bus.gnt, bus.din, e_gnt, e_din);
      end
      checks++;
      if (bus.wen !== (e_w >= 0)) begin
        failures++; $display("FAIL rand_wen cyc=%0d got=%b want=%b", c, bus.wen, (e_w >= 0));
      end
      checks++;
      if (bus.owner !== IW'(m_owner)) begin
        failures++; $display("FAIL rand_owner cyc=%0d got=%0d want=%0d", c, bus.owner, m_owner);
      end
      adv();
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.req    = '0;
    bus.full   = 1'b0;
    bus.din_in = '0;
    for (int i = 0; i < N; i++) m_din[i] = 8'hA0 + 8'(i);
    test_reset();
    test_rr_sequence();
    test_backpressure();
    test_single_requester();
    test_burst_pause();
    test_reset_midburst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
